hall_pulse_gen: RTL and testbench
=================================

Name: hall_pulse_gen

Overview:
- Transmitter side of the hall-sensor interface. Emulates an open-drain, active-low hall sensor by driving a programmable pulse train of magnet passes.
- Used to exercise and calibrate the hall-sensor/LED receive path on the board without a magnet or motor.
- Timing is defined in clock cycles: period, low time and pulse count are latched at start.

Parameters:
- PERIOD_W, 24, width of the period and low-time fields in clock cycles.
- CNT_W, 16, width of the pulse-count request and the pulse counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin a pulse train; sampled in IDLE only.
- stop  input  1  abort the train; honoured in any state.
- period  input  PERIOD_W  full pulse period in cycles; latched on accepted start.
- low_time  input  PERIOD_W  cycles hall_out is held low (magnet present) per period; latched on accepted start.
- num_pulses  input  CNT_W  pulses to emit; 0 means continuous until stop.
- hall_out  output  1  emulated sensor line, active-low; idle level is 1.
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle pulse when a finite train completes normally.
- cfg_err  output  1  one-cycle pulse when start is rejected because of an illegal configuration.
- pulse_count  output  CNT_W  falling edges emitted since the last accepted start.

Behaviour:
- Reset: one clk edge with rst=1 forces the following, regardless of state:
  - state IDLE;
  - hall_out=1, busy=0, done=0, cfg_err=0, pulse_count=0;
  - internal timers cleared.
- All outputs are registered.
- States: IDLE, LOW, HIGH.
- Accepting a start in IDLE:
  - Legal configuration: period>=2, low_time>=1, low_time<period.
  - Illegal configuration: start is ignored and cfg_err pulses in the cycle after start. State stays IDLE.
  - If start=1 and stop=1 in the same cycle: stop wins, start is ignored, no cfg_err.
  - On acceptance: latch period, low_time and num_pulses; clear pulse_count.
- Latency from an accepted start sampled at edge N:
  - at edge N+1, state=LOW, hall_out=0, busy=1, pulse_count=1.
- LOW phase:
  - hall_out stays 0 for exactly low_time cycles, then moves to HIGH.
- HIGH phase:
  - hall_out stays 1 for exactly period-low_time cycles.
  - At the end of the phase, if num_pulses=0 or pulse_count<num_pulses: enter LOW and increment pulse_count.
  - Otherwise: enter IDLE, busy=0, and done=1 for one cycle in the same cycle busy falls.
- Result: each pulse spans exactly period cycles, falling edge to falling edge.
- Continuous mode (num_pulses=0): pulse_count wraps modulo 2^CNT_W; busy stays high until stop.
- Finite mode: pulse_count equals num_pulses at done and holds until the next accepted start.
- stop while busy:
  - next edge: IDLE, hall_out=1, busy=0;
  - done is not asserted;
  - pulse_count holds its value.
- start while busy is ignored. Configuration inputs are don't-care outside IDLE.
- rst has priority over stop; stop has priority over phase transitions.
- done and cfg_err never assert in the same cycle.

Decomposition:
- Shared package/include hall_pkg holds:
  - state encodings: IDLE=2'd0, LOW=2'd1, HIGH=2'd2;
  - the minimum legal period constant, 2.
- One sub-module, hall_phase_timer:
  - loadable down-counter of PERIOD_W bits;
  - inputs: load, load_value, enable;
  - output: expire, a one-cycle pulse when the count reaches 1.
  - The FSM reloads it on entry to each phase.

Test Plan:
- Reset mid-train: period=10, low_time=4, num_pulses=0, assert rst during a LOW phase -> next cycle hall_out=1, busy=0, pulse_count=0, no done.
- Finite train: period=10, low_time=4, num_pulses=3, start at edge 0 ->
  - hall_out low on cycles 1-4, 11-14, 21-24;
  - done=1 and busy=0 at cycle 31;
  - pulse_count=3.
- Illegal configurations: period=5, low_time=5, start -> cfg_err one cycle, busy stays 0, hall_out stays 1. Repeat with period=1 and with low_time=0 -> same response.
- Abort and precedence:
  - continuous train (period=6, low_time=2), stop during the 5th pulse -> hall_out=1 and busy=0 next cycle, pulse_count=5, no done;
  - start and stop together in IDLE -> nothing happens.
- Continuous wrap: with CNT_W overridden to 4, period=2, low_time=1, num_pulses=0, run 17 pulses -> pulse_count goes 15 to 0 to 1, busy held high.
- Minimum period: period=2, low_time=1, num_pulses=2 -> hall_out sequence 0,1,0,1 then done, proving back-to-back phase reloads without gaps.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared definitions for the hall-sensor pulse generator.
// Holds FSM state encodings and the minimum legal pulse period.
package hall_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    // Shortest period that still leaves one LOW and one HIGH cycle.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/hall_pulse_gen_timer.sv
// Loadable phase down-counter for the hall pulse generator.
// Ports: clk, rst (sync, active-high), load/load_value reload the count,
// enable lets it count down, expire flags the last cycle of a phase.
module hall_phase_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_value,
    input  logic                enable,
    output logic                expire
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_value;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - PERIOD_W'(1);
        end
    end

    // A count of N is loaded on phase entry, so a value of 1 marks the
    // N-th (final) cycle of that phase.
    assign expire = enable && (r_cnt == PERIOD_W'(1));

endmodule

// File: rtl/hall_pulse_gen.sv
// Open-drain hall-sensor emulator: emits a train of active-low pulses.
// Ports: clk, rst (sync, active-high), start/stop control, period,
// low_time, num_pulses config; hall_out, busy, done, cfg_err,
// pulse_count status (all registered).
module hall_pulse_gen
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] low_time,
    input  logic [CNT_W-1:0]    num_pulses,
    output logic                hall_out,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    pulse_count
);

    logic [1:0]          r_state;
    logic [PERIOD_W-1:0] r_low;
    logic [PERIOD_W-1:0] r_high;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_pc;
    logic                r_hall;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_legal;
    logic                w_more;
    logic                w_expire;
    logic                w_load;
    logic                w_en;
    logic [PERIOD_W-1:0] w_load_val;

    assign w_legal = (period >= PERIOD_W'(MIN_PERIOD))
                  && (low_time != '0)
                  && (low_time < period);

    // Continuous mode (r_num == 0) never runs out of pulses.
    assign w_more = (r_num == '0) || (r_pc < r_num);

    assign w_en = (r_state != ST_IDLE);

    // Reload the timer on entry to every LOW or HIGH phase.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = r_low;
        if (!stop) begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_legal) begin
                        w_load     = 1'b1;
                        w_load_val = low_time;
                    end
                end
                ST_LOW: begin
                    if (w_expire) begin
                        w_load     = 1'b1;
                        w_load_val = r_high;
                    end
                end
                ST_HIGH: begin
                    if (w_expire && w_more) begin
                        w_load     = 1'b1;
                        w_load_val = r_low;
                    end
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    hall_phase_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (w_load_val),
        .enable     (w_en),
        .expire     (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_low   <= '0;
            r_high  <= '0;
            r_num   <= '0;
            r_pc    <= '0;
            r_hall  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (stop) begin
                // Abort: pulse_count is left untouched on purpose.
                r_state <= ST_IDLE;
                r_hall  <= 1'b1;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (w_legal) begin
                                r_low   <= low_time;
                                r_high  <= period - low_time;
                                r_num   <= num_pulses;
                                r_pc    <= CNT_W'(1);
                                r_state <= ST_LOW;
                                r_hall  <= 1'b0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_LOW: begin
                        if (w_expire) begin
                            r_state <= ST_HIGH;
                            r_hall  <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (w_expire) begin
                            if (w_more) begin
                                r_state <= ST_LOW;
                                r_hall  <= 1'b0;
                                r_pc    <= r_pc + CNT_W'(1);
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_hall  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hall_out    = r_hall;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_err;
    assign pulse_count = r_pc;

endmodule

// File: tb/tb_hall_pulse_gen.sv
// Scoreboard bench for hall_pulse_gen: a 16-bit counter instance and a
// 4-bit counter instance driven from the same stimulus.
module tb_hall_pulse_gen;

    typedef struct {
        bit          chk;
        logic        hall;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] period = '0;
    logic [23:0] low_time = '0;
    logic [15:0] num_pulses = '0;

    logic        hall_a, busy_a, done_a, err_a;
    logic [15:0] pc_a;
    logic        hall_b, busy_b, done_b, err_b;
    logic [3:0]  pc_b;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hall_pulse_gen #(.PERIOD_W(24), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period), .low_time(low_time), .num_pulses(num_pulses),
        .hall_out(hall_a), .busy(busy_a), .done(done_a),
        .cfg_err(err_a), .pulse_count(pc_a)
    );

    hall_pulse_gen #(.PERIOD_W(24), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period), .low_time(low_time), .num_pulses(num_pulses[3:0]),
        .hall_out(hall_b), .busy(busy_b), .done(done_b),
        .cfg_err(err_b), .pulse_count(pc_b)
    );

    function automatic exp_t mk(input logic h, input logic b,
                                input logic d, input logic e,
                                input int pc);
        exp_t x;
        x.chk  = 1'b1;
        x.hall = h;
        x.busy = b;
        x.done = d;
        x.err  = e;
        x.pc   = 16'(pc);
        return x;
    endfunction

    function automatic exp_t none();
        exp_t x;
        x = mk(1'b1, 1'b0, 1'b0, 1'b0, 0);
        x.chk = 1'b0;
        return x;
    endfunction

    // Cycle k (k>=1) of a running train started in cycle 0.
    function automatic exp_t train_exp(input int p, input int l,
                                       input int k, input int w);
        int ofs;
        int pc;
        ofs = (k - 1) % p;
        pc  = ((k - 1) / p + 1) & ((1 << w) - 1);
        return mk((ofs < l) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, pc);
    endfunction

    // Wait for the next edge, then queue what each DUT must show
    // for the cycle that edge opens.
    task automatic cyc(input exp_t ea, input exp_t eb);
        @(posedge clk);
        #1;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if (e.chk) begin
                total++;
                if ({hall_a, busy_a, done_a, err_a, pc_a} !==
                    {e.hall, e.busy, e.done, e.err, e.pc}) begin
                    bad++;
                    $display("FAIL dut_a t=%0t got h=%b b=%b d=%b e=%b pc=%0d want h=%b b=%b d=%b e=%b pc=%0d",
                             $time, hall_a, busy_a, done_a, err_a, pc_a,
                             e.hall, e.busy, e.done, e.err, e.pc);
                end
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            if (e.chk) begin
                total++;
                if ({hall_b, busy_b, done_b, err_b, 12'd0, pc_b} !==
                    {e.hall, e.busy, e.done, e.err, e.pc}) begin
                    bad++;
                    $display("FAIL dut_b t=%0t got h=%b b=%b d=%b e=%b pc=%0d want h=%b b=%b d=%b e=%b pc=%0d",
                             $time, hall_b, busy_b, done_b, err_b, pc_b,
                             e.hall, e.busy, e.done, e.err, e.pc);
                end
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        cyc(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));
        rst = 1'b0;
    endtask

    task automatic cfg(input int p, input int l, input int n);
        period     = 24'(p);
        low_time   = 24'(l);
        num_pulses = 16'(n);
    endtask

    task automatic finite_train(input int p, input int l, input int n);
        cfg(p, l, n);
        start = 1'b1;
        for (int k = 1; k <= n * p; k++) begin
            cyc(train_exp(p, l, k, 16), none());
            start = 1'b0;
        end
        cyc(mk(1, 0, 1, 0, n), none());
        cyc(mk(1, 0, 0, 0, n), none());
    endtask

    task automatic bad_cfg(input int p, input int l);
        cfg(p, l, 1);
        start = 1'b1;
        cyc(mk(1, 0, 0, 1, 0), none());
        start = 1'b0;
        cyc(mk(1, 0, 0, 0, 0), none());
        cyc(mk(1, 0, 0, 0, 0), none());
    endtask

    initial begin
        cyc(none(), none());
        do_reset();
        cyc(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));

        // Reset during a LOW phase of a continuous train.
        cfg(10, 4, 0);
        start = 1'b1;
        cyc(train_exp(10, 4, 1, 16), none());
        start = 1'b0;
        cyc(train_exp(10, 4, 2, 16), none());
        rst = 1'b1;
        cyc(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));
        rst = 1'b0;
        cyc(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));

        // Finite train 10/4 x3: low on 1-4, 11-14, 21-24, done at 31.
        finite_train(10, 4, 3);

        // Illegal configurations.
        do_reset();
        bad_cfg(5, 5);
        bad_cfg(1, 1);
        bad_cfg(10, 0);

        // Start and stop together in IDLE.
        cfg(10, 4, 0);
        start = 1'b1;
        stop  = 1'b1;
        cyc(mk(1, 0, 0, 0, 0), none());
        start = 1'b0;
        stop  = 1'b0;
        cyc(mk(1, 0, 0, 0, 0), none());

        // Continuous 6/2, stop inside the 5th pulse (cycles 25-30).
        cfg(6, 2, 0);
        start = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            cyc(train_exp(6, 2, k, 16), none());
            start = 1'b0;
        end
        stop = 1'b1;
        cyc(mk(1, 0, 0, 0, 5), none());
        stop = 1'b0;
        cyc(mk(1, 0, 0, 0, 5), none());
        cyc(mk(1, 0, 0, 0, 5), none());

        // Continuous 2/1: 4-bit counter wraps 15 -> 0 -> 1.
        do_reset();
        cfg(2, 1, 0);
        start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            cyc(train_exp(2, 1, k, 16), train_exp(2, 1, k, 4));
            start = 1'b0;
        end
        stop = 1'b1;
        cyc(mk(1, 0, 0, 0, 18), mk(1, 0, 0, 0, 2));
        stop = 1'b0;

        // Minimum period, two pulses: 0,1,0,1 then done.
        finite_train(2, 1, 2);

        // Start while busy is ignored.
        cfg(4, 1, 1);
        start = 1'b1;
        cyc(mk(0, 1, 0, 0, 1), none());
        cfg(8, 3, 5);
        cyc(mk(1, 1, 0, 0, 1), none());
        cyc(mk(1, 1, 0, 0, 1), none());
        cyc(mk(1, 1, 0, 0, 1), none());
        start = 1'b0;
        cyc(mk(1, 0, 1, 0, 1), none());

        @(negedge clk);
        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain qa=%0d qb=%0d want 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
